// File: rtl/seq_pkg.sv
// Shared definitions for the multicycle LEGv8 control path: sequencer state
// encoding, fault codes and the decoder-bank word widths.
package seq_pkg;

    localparam int CW_W_DEF = 31;
    localparam int K_W_DEF  = 64;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_EXEC  = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_FAULT = 2'd3;

    localparam logic [1:0] FC_NONE     = 2'b00;
    localparam logic [1:0] FC_TIMEOUT  = 2'b01;
    localparam logic [1:0] FC_OVERFLOW = 2'b10;

endpackage

// File: rtl/stall_timer.sv
// Loadable wait counter for memory micro-steps; at_limit flags the cycle the
// count equals TIMEOUT.
module stall_timer #(
    parameter int TIMEOUT = 15,
    parameter int CNT_W   = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic clear,
    input  logic inc,
    output logic at_limit
);

    logic [CNT_W-1:0] count_d, count_q;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (load) begin
            count_d = CNT_W'(1);
        end else if (inc) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign at_limit = (count_q == CNT_W'(TIMEOUT));

endmodule

// File: rtl/multicycle_sequencer.sv
// Micro-step sequencer: latches an instruction, walks the decoder bank's
// micro-states, stalls on memory steps and faults on timeout or runaway.
module multicycle_sequencer
    import seq_pkg::*;
#(
    parameter int CW_W    = CW_W_DEF,
    parameter int K_W     = K_W_DEF,
    parameter int STATE_W = 3,
    parameter int TIMEOUT = 15
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [31:0]        instr_in,
    input  logic               instr_valid,
    output logic               instr_ready,
    output logic [31:0]        ir,
    output logic [STATE_W-1:0] ustate,
    input  logic [CW_W-1:0]    dec_cw,
    input  logic [K_W-1:0]     dec_k,
    input  logic [STATE_W-1:0] dec_next,
    input  logic               dec_last,
    input  logic               dec_mem,
    input  logic               mem_ready,
    output logic [CW_W-1:0]    controlword,
    output logic [K_W-1:0]     constant,
    output logic               cw_valid,
    output logic               retire,
    output logic               fault,
    output logic [1:0]         fault_code
);

    localparam logic [STATE_W-1:0] STEP_MAX = '1;

    logic [1:0]         state_d, state_q;
    logic [31:0]        ir_d, ir_q;
    logic [STATE_W-1:0] ustate_d, ustate_q;
    logic [STATE_W-1:0] step_d, step_q;
    logic               fault_d, fault_q;
    logic [1:0]         fault_code_d, fault_code_q;

    logic step_done, overflow;
    logic tmr_load, tmr_clear, tmr_inc, tmr_at_limit;

    always_comb begin
        state_d      = state_q;
        ir_d         = ir_q;
        ustate_d     = ustate_q;
        step_d       = step_q;
        fault_d      = fault_q;
        fault_code_d = fault_code_q;
        instr_ready  = 1'b0;
        cw_valid     = 1'b0;
        retire       = 1'b0;
        tmr_load     = 1'b0;
        tmr_clear    = 1'b0;
        tmr_inc      = 1'b0;
        step_done    = 1'b0;
        overflow     = !dec_last && (step_q == STEP_MAX);

        case (state_q)
            ST_IDLE: begin
                instr_ready = 1'b1;
                if (instr_valid) begin
                    ir_d     = instr_in;
                    ustate_d = '0;
                    step_d   = '0;
                    state_d  = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (!dec_mem || mem_ready) begin
                    step_done = 1'b1;
                end else begin
                    tmr_load = 1'b1;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // mem_ready takes priority over a timeout reached this cycle
                if (mem_ready) begin
                    tmr_clear = 1'b1;
                    step_done = 1'b1;
                end else if (tmr_at_limit) begin
                    state_d      = ST_FAULT;
                    fault_d      = 1'b1;
                    fault_code_d = FC_TIMEOUT;
                end else begin
                    tmr_inc = 1'b1;
                end
            end
            default: ;
        endcase

        // A runaway step is swallowed: it raises the fault instead of committing.
        if (step_done) begin
            if (overflow) begin
                state_d      = ST_FAULT;
                fault_d      = 1'b1;
                fault_code_d = FC_OVERFLOW;
            end else begin
                cw_valid = 1'b1;
                if (dec_last) begin
                    retire  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    ustate_d = dec_next;
                    step_d   = step_q + 1'b1;
                    state_d  = ST_EXEC;
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            ir_q         <= '0;
            ustate_q     <= '0;
            step_q       <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= FC_NONE;
        end else begin
            state_q      <= state_d;
            ir_q         <= ir_d;
            ustate_q     <= ustate_d;
            step_q       <= step_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
        end
    end

    stall_timer #(
        .TIMEOUT(TIMEOUT),
        .CNT_W  (8)
    ) u_stall_timer (
        .clock   (clock),
        .reset   (reset),
        .load    (tmr_load),
        .clear   (tmr_clear),
        .inc     (tmr_inc),
        .at_limit(tmr_at_limit)
    );

    assign ir          = ir_q;
    assign ustate      = ustate_q;
    assign controlword = cw_valid ? dec_cw : '0;
    assign constant    = cw_valid ? dec_k : '0;
    assign fault       = fault_q;
    assign fault_code  = fault_code_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer: a small decoder bank and memory
// model drive the DUT, a step-level reference model is compared every cycle.
module tb_multicycle_sequencer;

    localparam int CW_W    = 31;
    localparam int K_W     = 64;
    localparam int STATE_W = 3;
    localparam int TIMEOUT = 15;

    localparam logic [31:0] I_ALU  = 32'h9100_0400;
    localparam logic [31:0] I_LOAD = 32'hF840_0001;
    localparam logic [31:0] I_RUN  = 32'hAA00_0002;
    localparam logic [31:0] I_MEM  = 32'hF800_0003;
    localparam logic [31:0] I_ADD  = 32'h8B02_0020;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic [31:0]        instr_in = '0;
    logic               instr_valid = 1'b0;
    logic               instr_ready;
    logic [31:0]        ir;
    logic [STATE_W-1:0] ustate;
    logic [CW_W-1:0]    dec_cw;
    logic [K_W-1:0]     dec_k;
    logic [STATE_W-1:0] dec_next;
    logic               dec_last;
    logic               dec_mem;
    logic               mem_ready;
    logic [CW_W-1:0]    controlword;
    logic [K_W-1:0]     constant;
    logic               cw_valid;
    logic               retire;
    logic               fault;
    logic [1:0]         fault_code;

    int n_pass  = 0;
    int n_total = 0;
    bit chk_en  = 1'b0;
    int mem_lat = 0;
    int mem_cnt = 0;

    multicycle_sequencer #(
        .CW_W(CW_W), .K_W(K_W), .STATE_W(STATE_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .instr_in(instr_in), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .ir(ir), .ustate(ustate),
        .dec_cw(dec_cw), .dec_k(dec_k), .dec_next(dec_next),
        .dec_last(dec_last), .dec_mem(dec_mem), .mem_ready(mem_ready),
        .controlword(controlword), .constant(constant),
        .cw_valid(cw_valid), .retire(retire),
        .fault(fault), .fault_code(fault_code)
    );

    always #5 clock = ~clock;

    // Micro-programs selected by ir[1:0]: 0 ALU (3 steps), 1 load (mem at step 1),
    // 2 runaway (never last), 3 single memory step.  Returns {mem, last, next}.
    function automatic logic [4:0] ustep(input logic [31:0] i, input logic [2:0] us);
        logic [2:0] nx;
        nx = us + 3'd1;
        case (i[1:0])
            2'd0:    return {1'b0, us == 3'd2, nx};
            2'd1:    return {us == 3'd1, us == 3'd2, nx};
            2'd2:    return {1'b0, 1'b0, nx};
            default: return {1'b1, 1'b1, 3'd0};
        endcase
    endfunction

    function automatic logic [CW_W-1:0] cw_of(input logic [31:0] i, input logic [2:0] us);
        return {i[27:0], us};
    endfunction

    function automatic logic [K_W-1:0] k_of(input logic [31:0] i, input logic [2:0] us);
        return {i, 29'd0, us};
    endfunction

    always_comb begin
        logic [4:0] s;
        s        = ustep(ir, ustate);
        dec_mem  = s[4];
        dec_last = s[3];
        dec_next = s[2:0];
        dec_cw   = cw_of(ir, ustate);
        dec_k    = k_of(ir, ustate);
    end

    // Memory answers after mem_lat cycles of a presented access.
    assign mem_ready = dec_mem && (mem_cnt >= mem_lat);
    always @(posedge clock) begin
        if (reset || instr_ready || !dec_mem || mem_ready) mem_cnt <= 0;
        else mem_cnt <= mem_cnt + 1;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: instruction in flight, steps committed, stall length.
    logic        m_busy = 1'b0, m_fault = 1'b0;
    logic [1:0]  m_code = 2'b00;
    logic [31:0] m_ir = '0;
    logic [2:0]  m_us = '0;
    int          m_steps = 0, m_stall = 0;

    always @(negedge clock) begin
        logic [4:0] s;
        logic ok, ovf, e_cw, e_ret;
        s     = ustep(m_ir, m_us);
        ok    = !s[4] || mem_ready;
        ovf   = !s[3] && (m_steps == (1 << STATE_W) - 1);
        e_cw  = m_busy && !m_fault && ok && !ovf;
        e_ret = e_cw && s[3];
        if (chk_en) begin
            check("instr_ready", instr_ready, !m_busy && !m_fault);
            check("cw_valid", cw_valid, e_cw);
            check("retire", retire, e_ret);
            check("controlword", controlword, e_cw ? cw_of(m_ir, m_us) : '0);
            check("constant", constant, e_cw ? k_of(m_ir, m_us) : '0);
            check("fault", fault, m_fault);
            check("fault_code", fault_code, m_code);
            check("ir", ir, m_ir);
            if (m_busy && !m_fault) check("ustate", ustate, m_us);
        end
        if (reset) begin
            m_busy = 1'b0; m_fault = 1'b0; m_code = 2'b00;
            m_ir = '0; m_us = '0; m_steps = 0; m_stall = 0;
        end else if (!m_fault) begin
            if (!m_busy) begin
                if (instr_valid) begin
                    m_busy = 1'b1; m_ir = instr_in; m_us = '0; m_steps = 0; m_stall = 0;
                end
            end else if (ok) begin
                m_stall = 0;
                if (ovf) begin
                    m_fault = 1'b1; m_code = 2'b10;
                end else if (s[3]) begin
                    m_busy = 1'b0;
                end else begin
                    m_us = s[2:0]; m_steps++;
                end
            end else begin
                m_stall++;
                if (m_stall == TIMEOUT + 1) begin
                    m_fault = 1'b1; m_code = 2'b01;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        next_cycle();
        reset = 1'b0;
    endtask

    // Issue one instruction from an idle DUT and follow it for up to max_cyc cycles.
    task automatic run_instr(input logic [31:0] ins, input int max_cyc,
                             output int commits, output int end_cyc,
                             output logic retired, output logic faulted,
                             output logic [CW_W-1:0] first_cw);
        commits = 0; end_cyc = 0; retired = 1'b0; faulted = 1'b0; first_cw = '0;
        instr_in = ins;
        instr_valid = 1'b1;
        next_cycle();
        instr_valid = 1'b0;
        for (int i = 1; i <= max_cyc; i++) begin
            @(negedge clock);
            if (cw_valid) begin
                if (commits == 0) first_cw = controlword;
                commits++;
            end
            if (retire || fault) begin
                end_cyc = i; retired = retire; faulted = fault;
                break;
            end
        end
        next_cycle();
    endtask

    int               commits, end_cyc, extra;
    logic             retired, faulted;
    logic [CW_W-1:0]  first_cw;

    initial begin
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset  = 1'b0;
        chk_en = 1'b1;

        @(negedge clock);
        check("reset instr_ready", instr_ready, 1'b1);
        check("reset ir", ir, 32'h0);
        check("reset fault", fault, 1'b0);
        check("reset fault_code", fault_code, 2'b00);
        check("reset controlword", controlword, 31'h0);
        next_cycle();

        // Three-step ALU instruction
        mem_lat = 0;
        run_instr(I_ALU, 20, commits, end_cyc, retired, faulted, first_cw);
        check("alu commits", commits, 3);
        check("alu retire cycle", end_cyc, 3);
        check("alu retired", retired, 1'b1);
        check("alu first controlword", first_cw, 31'h0800_2000);
        @(negedge clock);
        check("alu ready after retire", instr_ready, 1'b1);
        next_cycle();

        // Load with a 4-cycle memory
        mem_lat = 4;
        run_instr(I_LOAD, 30, commits, end_cyc, retired, faulted, first_cw);
        check("load commits", commits, 3);
        check("load retire cycle", end_cyc, 7);
        check("load stall cycles", end_cyc - commits, 4);

        // Memory answers exactly when the wait counter reaches TIMEOUT
        mem_lat = 15;
        run_instr(I_MEM, 40, commits, end_cyc, retired, faulted, first_cw);
        check("boundary commits", commits, 1);
        check("boundary retire cycle", end_cyc, 16);
        check("boundary no fault", {faulted, fault}, 2'b00);

        // Memory never answers
        mem_lat = 1000;
        run_instr(I_MEM, 40, commits, end_cyc, retired, faulted, first_cw);
        check("timeout fault cycle", end_cyc, 17);
        check("timeout faulted", faulted, 1'b1);
        check("timeout commits", commits, 0);
        repeat (2) next_cycle();
        @(negedge clock);
        check("timeout fault_code", fault_code, 2'b01);
        check("timeout controlword", controlword, 31'h0);
        check("timeout instr_ready", instr_ready, 1'b0);
        next_cycle();
        pulse_reset();

        // Runaway micro-sequence
        mem_lat = 0;
        run_instr(I_RUN, 30, commits, end_cyc, retired, faulted, first_cw);
        check("overflow commits", commits, 7);
        check("overflow fault cycle", end_cyc, 9);
        extra = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            if (cw_valid) extra++;
        end
        check("overflow no 8th commit", extra, 0);
        check("overflow fault_code", fault_code, 2'b10);
        next_cycle();
        pulse_reset();

        // Reset while stalled in WAIT, then a fresh instruction
        mem_lat = 1000;
        run_instr(I_LOAD, 4, commits, end_cyc, retired, faulted, first_cw);
        check("pre-reset commits", commits, 1);
        pulse_reset();
        @(negedge clock);
        check("post-reset ir", ir, 32'h0);
        check("post-reset instr_ready", instr_ready, 1'b1);
        next_cycle();
        mem_lat = 0;
        run_instr(I_ADD, 20, commits, end_cyc, retired, faulted, first_cw);
        check("post-reset commits", commits, 3);
        check("post-reset retire cycle", end_cyc, 3);
        @(negedge clock);
        check("post-reset fault", fault, 1'b0);
        check("post-reset ir latched", ir, I_ADD);
        next_cycle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Parametrised micro-step sequencer for the multicycle LEGv8 control path. It latches an instruction, walks an N-bit micro-state from 0 along the next-state values returned by the format decoder bank, and gates the decoder's control word and constant onto the datapath. It stalls on memory micro-steps until memory is ready, and faults on a memory timeout or a runaway micro-sequence. It replaces the fixed 2-bit state register that the per-format decoders currently feed.

Parameters:
CW_W, 31, control word width (excluding next-state bits)
K_W, 64, constant width
STATE_W, 3, micro-state width; max micro-steps per instruction = 2**STATE_W
TIMEOUT, 15, max consecutive stalled cycles on one memory micro-step (1..255)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high
instr_in  in  32  instruction from fetch
instr_valid  in  1  instr_in is valid
instr_ready  out  1  sequencer accepts an instruction this cycle
ir  out  32  latched instruction, drives decoder bank
ustate  out  STATE_W  current micro-state, drives decoder bank
dec_cw  in  CW_W  decoder control word for (ir, ustate)
dec_k  in  K_W  decoder constant
dec_next  in  STATE_W  decoder next micro-state
dec_last  in  1  this micro-step completes the instruction
dec_mem  in  1  this micro-step needs memory
mem_ready  in  1  memory completes the access this cycle
controlword  out  CW_W  gated control word: dec_cw when cw_valid, else 0
constant  out  K_W  gated constant: dec_k when cw_valid, else 0
cw_valid  out  1  datapath commits this micro-step this cycle
retire  out  1  one-cycle pulse on the last committed micro-step
fault  out  1  sticky error flag
fault_code  out  2  01 = memory timeout, 10 = micro-step overflow, 00 = none

Behaviour:
- States: IDLE, EXEC, WAIT, FAULT.
- Reset values: state=IDLE, ir=0, ustate=0, wait counter=0, step counter=0, fault=0, fault_code=00. All outputs are 0 except instr_ready, which is 1 in IDLE.
- IDLE:
  - instr_ready=1.
  - If instr_valid: ir<=instr_in, ustate<=0, step counter<=0, go to EXEC.
  - cw_valid=0.
- EXEC: commit = !dec_mem || mem_ready.
  - If commit: cw_valid=1.
    - If dec_last: retire=1, go to IDLE.
    - Else: ustate<=dec_next, step counter +1, stay in EXEC.
  - If not commit: cw_valid=0, wait counter<=1, go to WAIT.
- WAIT:
  - ustate is frozen, so the decoder outputs stay stable.
  - If mem_ready: commit exactly as in EXEC, wait counter<=0, go to IDLE if dec_last, else to EXEC.
  - Else if wait counter==TIMEOUT: go to FAULT, fault_code=01.
  - Else: wait counter +1.
- Step overflow: if a non-last commit occurs while step counter == 2**STATE_W-1, go to FAULT with fault_code=10. No commit is emitted for that step.
- FAULT:
  - controlword=0, constant=0, cw_valid=0, instr_ready=0.
  - Stays in FAULT until reset.
- Commit count: exactly one cw_valid cycle per micro-step. A stall never duplicates a commit.
- Latency:
  - An instruction accepted at cycle t has its first commit at t+1 at the earliest.
  - There is one IDLE bubble between retire and the next accept (no same-cycle accept).
- Simultaneous events:
  - mem_ready in the same cycle the timeout is reached: mem_ready wins, and the step commits.
  - Reset mid-instruction or in FAULT: everything returns to reset values on the next edge; the partial instruction is discarded.
- dec_next is ignored when dec_last=1. The ustate width wraps naturally; overflow is caught by the step counter, not by wrap-around.

Decomposition:
- Shared package seq_pkg holds:
  - the state encoding (IDLE=0, EXEC=1, WAIT=2, FAULT=3);
  - the fault codes;
  - CW_W and K_W defaults, shared with the decoders.
- One natural sub-module: stall_timer, a loadable wait counter with a terminal flag at TIMEOUT.

Test Plan:
- Three-step ALU instruction: no dec_mem; dec_next 0→1→2, dec_last at ustate 2. Required: cw_valid on 3 consecutive cycles, retire in the 3rd, instr_ready back to 1 the next cycle.
- Load with 4-cycle memory: dec_mem=1 at ustate 1, mem_ready low for 4 cycles. Required: ustate holds 1, cw_valid=0 for 4 cycles, then a single commit; total commits = 3.
- Timeout with TIMEOUT=15: mem_ready never rises. Required: fault=1 and fault_code=01 exactly 16 cycles after the stall starts; controlword=0 afterwards.
- Boundary: mem_ready rises in the cycle the wait counter equals 15. Required: commit occurs and no fault.
- Overflow with STATE_W=3: dec_last is never asserted. Required: 7 commits, then FAULT with fault_code=10, and no 8th cw_valid.
- Reset asserted in WAIT, then a new instruction 0x8B020020. Required: ir=0 and instr_ready=1 one cycle after reset; the new instruction is accepted normally; fault stays 0.
